pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic, parametrised pipeline-stage register for the riscv_pipelined core; successor to the fixed per-stage regs.
//  Carries an opaque WIDTH-bit payload between stages using a valid/ready handshake, with an optional 2-entry skid.
//  Supports flush (bubble insert), a programmable reset/bubble payload and a saturating stall-cycle counter.
//  Sits between any two stages (IF/ID ... M/WB); stage-specific fields are packed into the payload by the caller.
// PARAMETERS
//  WIDTH          39      payload bits (e.g. rd_addr 5 + rd 32 + writeback_en 1 + writeback_from_mem 1)
//  RESET_PAYLOAD  '0      payload value loaded into every slot on rst and on flush (the bubble/NOP encoding)
//  SKID           1       1: two slots, in_ready registered; 0: one slot, in_ready combinational
//  CNT_W          16      width of stall_cnt
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      upstream has a payload
//  in_ready   out  1      stage can accept; transfer when in_valid && in_ready
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      head slot holds a live payload
//  out_ready  in   1      downstream accepts; transfer when out_valid && out_ready
//  out_data   out  WIDTH  head slot payload
//  flush      in   1      discard all held payloads this cycle
//  stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating
//  clr_cnt    in   1      synchronous clear of stall_cnt
// BEHAVIOUR
//  Reset (rst=1 at posedge): all slot valids 0, all slot payloads = RESET_PAYLOAD, stall_cnt 0; in_ready reads 1 from
//   the next cycle (SKID=1); out_valid 0, out_data = RESET_PAYLOAD. Reset mid-transfer drops held and incoming payloads.
//  Latency: 1 cycle in_data -> out_data when empty; strict FIFO order, no drop, no duplication.
//  Occupancy FSM (SKID=1): EMPTY(0) / HALF(1) / FULL(2).
//   EMPTY: push -> HALF.  HALF: push&!pop -> FULL; pop&!push -> EMPTY; push&pop -> HALF (head replaced).
//   FULL: pop -> HALF (skid slot moves to head); push impossible (in_ready=0).
//   in_ready = (state != FULL), a pure register output; no combinational in_ready<-out_ready path.
//  SKID=0: single slot; in_ready = !out_valid || out_ready; push&pop same cycle replaces payload, out_valid stays 1.
//  out_data holds last payload while out_valid=0 (only rst/flush reload RESET_PAYLOAD); consumers qualify with out_valid.
//  flush: priority over push/pop; next state EMPTY, payloads = RESET_PAYLOAD, any in_valid&&in_ready that cycle is
//   dropped (upstream sees it accepted, must be flushed itself). rst has priority over flush.
//  stall_cnt: +1 each cycle out_valid && !out_ready; holds at 2^CNT_W-1; clr_cnt -> 0 (clr wins over increment);
//   flush does not clear it.
//  Payload never interpreted; X on in_data while in_valid=0 must not propagate into stored state.
// STRUCTURE
//  Shared package pipe_pkg: typedef enum logic [1:0] {OCC_EMPTY, OCC_HALF, OCC_FULL} pipe_occ_e; stage payload
//   struct typedefs (e.g. m_wb_payload_t) and their NOP constants used as RESET_PAYLOAD.
//  One sub-module: pipe_slot (WIDTH-bit register + valid, load/clear/reset-value inputs), instantiated 1 or 2 times
//   via generate on SKID. FSM, handshake and stall counter live in pipe_stage_reg.
// TESTING
//  1 rst for 2 cycles, RESET_PAYLOAD=39'h5 -> out_valid=0, out_data=39'h5, stall_cnt=0, in_ready=1 next cycle.
//  2 stream 0x01..0x10 with out_ready=1 -> same sequence out, 1-cycle latency, in_ready never drops.
//  3 SKID=1: push 0xA,0xB with out_ready=0 -> FULL, in_ready=0; out_ready=1 -> 0xA then 0xB, in_ready=1 after 1st pop.
//  4 FULL + flush=1 with in_valid=1 (0xC) -> next cycle out_valid=0, out_data=RESET_PAYLOAD, 0xC never emitted.
//  5 hold out_valid=1, out_ready=0 for 5 cycles, CNT_W=2 -> stall_cnt 1,2,3,3,3; clr_cnt -> 0.
//  6 random in_valid/out_ready/flush 10k cycles, SKID=0 and 1 -> scoreboard order exact, no loss outside flush.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipelined core's stage registers: occupancy states and
// stage payload layouts with their bubble (NOP) encodings.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HALF  = 2'd1,
        OCC_FULL  = 2'd2
    } pipe_occ_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_payload_t;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd;
        logic        writeback_en;
        logic        writeback_from_mem;
    } m_wb_payload_t;

    localparam int unsigned M_WB_W = $bits(m_wb_payload_t);

    // addi x0, x0, 0 is the canonical bubble for the decode stage
    localparam if_id_payload_t IF_ID_NOP = '{pc: 32'h0000_0000, instr: 32'h0000_0013};

    localparam m_wb_payload_t M_WB_NOP = '{
        rd_addr:            5'd0,
        rd:                 32'd0,
        writeback_en:       1'b0,
        writeback_from_mem: 1'b0
    };

endpackage

// File: rtl/pipe_slot.sv
// One payload slot of a pipeline stage register: data register plus valid bit.
// Reset and clear both reload the bubble payload and drop the valid bit.
module pipe_slot #(
    parameter int unsigned WIDTH = 39
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             valid_nxt,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] rst_value,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // Data only moves on an explicit load, so an idle in_data never reaches state
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_r <= 1'b0;
            data_r  <= rst_value;
        end else begin
            valid_r <= valid_nxt;
            if (load) begin
                data_r <= d;
            end
        end
    end

    assign valid = valid_r;
    assign q     = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline-stage register with optional 2-entry skid,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH         = 39,
    parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0,
    parameter bit               SKID          = 1'b1,
    parameter int unsigned      CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             clr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_occ_e        occ_r;
    pipe_occ_e        occ_s;
    logic             in_ready_r;
    logic             push_s;
    logic             pop_s;
    logic             head_load_s;
    logic             head_valid_nxt_s;
    logic [WIDTH-1:0] head_d_s;
    logic             head_valid_s;
    logic [WIDTH-1:0] head_data_s;
    logic             skid_load_s;
    logic             skid_valid_nxt_s;
    logic             skid_valid_s;
    logic [WIDTH-1:0] skid_data_s;
    logic [CNT_W-1:0] cnt_r;

    assign push_s = in_valid && in_ready;
    assign pop_s  = head_valid_s && out_ready;

    // Occupancy next-state and slot load/valid control
    always_comb begin
        occ_s            = occ_r;
        head_load_s      = 1'b0;
        head_d_s         = in_data;
        head_valid_nxt_s = head_valid_s;
        skid_load_s      = 1'b0;
        skid_valid_nxt_s = skid_valid_s;
        case (occ_r)
            OCC_EMPTY: begin
                if (push_s) begin
                    occ_s            = OCC_HALF;
                    head_load_s      = 1'b1;
                    head_valid_nxt_s = 1'b1;
                end else begin
                    occ_s = OCC_EMPTY;
                end
            end
            OCC_HALF: begin
                if (push_s && !pop_s) begin
                    occ_s            = OCC_FULL;
                    skid_load_s      = 1'b1;
                    skid_valid_nxt_s = 1'b1;
                end else if (pop_s && !push_s) begin
                    occ_s            = OCC_EMPTY;
                    head_valid_nxt_s = 1'b0;
                end else if (push_s && pop_s) begin
                    occ_s       = OCC_HALF;
                    head_load_s = 1'b1;
                end else begin
                    occ_s = OCC_HALF;
                end
            end
            OCC_FULL: begin
                // Skid entry becomes the head; in_ready is low so nothing arrives
                if (pop_s) begin
                    occ_s            = OCC_HALF;
                    head_load_s      = 1'b1;
                    head_d_s         = skid_data_s;
                    skid_valid_nxt_s = 1'b0;
                end else begin
                    occ_s = OCC_FULL;
                end
            end
            default: begin
                occ_s            = OCC_EMPTY;
                head_valid_nxt_s = 1'b0;
                skid_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Occupancy state register; flush empties the stage
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r <= OCC_EMPTY;
        end else if (flush) begin
            occ_r <= OCC_EMPTY;
        end else begin
            occ_r <= occ_s;
        end
    end

    // Registered in_ready for the skid variant, cutting the out_ready -> in_ready path
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= (occ_s != OCC_FULL);
        end
    end

    pipe_slot #(.WIDTH(WIDTH)) u_head (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .load      (head_load_s),
        .valid_nxt (head_valid_nxt_s),
        .d         (head_d_s),
        .rst_value (RESET_PAYLOAD),
        .valid     (head_valid_s),
        .q         (head_data_s)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(.WIDTH(WIDTH)) u_skid (
                .clk       (clk),
                .rst       (rst),
                .clr       (flush),
                .load      (skid_load_s),
                .valid_nxt (skid_valid_nxt_s),
                .d         (in_data),
                .rst_value (RESET_PAYLOAD),
                .valid     (skid_valid_s),
                .q         (skid_data_s)
            );
            assign in_ready = in_ready_r;
        end else begin : g_noskid
            assign skid_valid_s = 1'b0;
            assign skid_data_s  = RESET_PAYLOAD;
            assign in_ready     = !head_valid_s || out_ready;
        end
    endgenerate

    // Saturating stall counter; clear beats increment, flush leaves it alone
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_r <= '0;
        end else if (head_valid_s && !out_ready && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign out_valid = head_valid_s;
    assign out_data  = head_data_s;
    assign stall_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: instance 0 has SKID=0, instance 1 SKID=1,
// both with RESET_PAYLOAD=39'h5 and a 2-bit stall counter.
module tb_pipe_stage_reg;

    localparam int W = 39;
    localparam logic [W-1:0] RP = 39'h5;

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         clr;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic         e_ir;
        logic [1:0]   e_cnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [2];
    logic         ir   [2];
    logic [W-1:0] id   [2];
    logic         ov   [2];
    logic         ordy [2];
    logic [W-1:0] od   [2];
    logic         fl   [2];
    logic [1:0]   cnt  [2];
    logic         clr  [2];

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model: up to two queued payloads per instance
    logic [W-1:0] m_q    [2][2];
    int           m_n    [2];
    logic [W-1:0] m_last [2];
    int           m_sc   [2];

    vec_t vecs [19];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_stage_reg #(
            .WIDTH(W), .RESET_PAYLOAD(RP), .SKID(g == 1), .CNT_W(2)
        ) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]),
            .flush(fl[g]), .stall_cnt(cnt[g]), .clr_cnt(clr[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int k);
        iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b1; fl[k] = 1'b0; clr[k] = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_last[k] = RP; m_sc[k] = 0;
        end
    endtask

    function automatic logic model_ir(input int k);
        if (k == 1) return (m_n[k] < 2);
        else        return (m_n[k] == 0) || ordy[k];
    endfunction

    task automatic model_step(input int k);
        logic push;
        logic pop;
        push = iv[k] && model_ir(k);
        pop  = (m_n[k] > 0) && ordy[k];
        if (clr[k])                                 m_sc[k] = 0;
        else if (m_n[k] > 0 && !ordy[k] && m_sc[k] < 3) m_sc[k] = m_sc[k] + 1;
        if (fl[k]) begin
            m_n[k] = 0; m_last[k] = RP;
        end else begin
            if (pop) begin
                m_q[k][0] = m_q[k][1]; m_n[k] = m_n[k] - 1;
            end
            if (push) begin
                m_q[k][m_n[k]] = id[k]; m_n[k] = m_n[k] + 1;
            end
            if (m_n[k] > 0) m_last[k] = m_q[k][0];
        end
    endtask

    function automatic vec_t mk(input logic iv_i, input logic [W-1:0] d, input logic o, input logic f,
                                input logic c, input logic eov, input logic [W-1:0] eod,
                                input logic eir, input logic [1:0] ec);
        vec_t v;
        v.iv = iv_i; v.d = d; v.ordy = o; v.fl = f; v.clr = c;
        v.e_ov = eov; v.e_od = eod; v.e_ir = eir; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        // skid fill/drain, flush with pending push, stall saturation and clear (SKID=1)
        vecs[0]  = mk(1'b1, 39'hA,  1'b0, 1'b0, 1'b0, 1'b1, 39'hA,  1'b1, 2'd0);
        vecs[1]  = mk(1'b1, 39'hB,  1'b0, 1'b0, 1'b0, 1'b1, 39'hA,  1'b0, 2'd1);
        vecs[2]  = mk(1'b0, 39'h0,  1'b1, 1'b0, 1'b0, 1'b1, 39'hB,  1'b1, 2'd1);
        vecs[3]  = mk(1'b0, 39'h0,  1'b1, 1'b0, 1'b0, 1'b0, 39'hB,  1'b1, 2'd1);
        vecs[4]  = mk(1'b0, 39'h0,  1'b0, 1'b0, 1'b1, 1'b0, 39'hB,  1'b1, 2'd0);
        vecs[5]  = mk(1'b1, 39'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 39'hA1, 1'b1, 2'd0);
        vecs[6]  = mk(1'b1, 39'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 39'hA1, 1'b0, 2'd1);
        vecs[7]  = mk(1'b1, 39'hC,  1'b0, 1'b1, 1'b0, 1'b0, RP,     1'b1, 2'd2);
        vecs[8]  = mk(1'b1, 39'hD,  1'b0, 1'b0, 1'b0, 1'b1, 39'hD,  1'b1, 2'd2);
        vecs[9]  = mk(1'b1, 39'hE,  1'b1, 1'b1, 1'b0, 1'b0, RP,     1'b1, 2'd2);
        vecs[10] = mk(1'b0, 39'h0,  1'b1, 1'b0, 1'b0, 1'b0, RP,     1'b1, 2'd2);
        vecs[11] = mk(1'b1, 39'hF,  1'b0, 1'b0, 1'b1, 1'b1, 39'hF,  1'b1, 2'd0);
        vecs[12] = mk(1'b0, 39'h0,  1'b0, 1'b0, 1'b0, 1'b1, 39'hF,  1'b1, 2'd1);
        vecs[13] = mk(1'b0, 39'h0,  1'b0, 1'b0, 1'b0, 1'b1, 39'hF,  1'b1, 2'd2);
        vecs[14] = mk(1'b0, 39'h0,  1'b0, 1'b0, 1'b0, 1'b1, 39'hF,  1'b1, 2'd3);
        vecs[15] = mk(1'b0, 39'h0,  1'b0, 1'b0, 1'b0, 1'b1, 39'hF,  1'b1, 2'd3);
        vecs[16] = mk(1'b0, 39'h0,  1'b0, 1'b0, 1'b0, 1'b1, 39'hF,  1'b1, 2'd3);
        vecs[17] = mk(1'b0, 39'h0,  1'b0, 1'b0, 1'b1, 1'b1, 39'hF,  1'b1, 2'd0);
        vecs[18] = mk(1'b0, 39'h0,  1'b1, 1'b0, 1'b0, 1'b0, 39'hF,  1'b1, 2'd0);

        rst = 1'b1;
        idle(0); idle(1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_out_valid", 64'(ov[k]), 64'd0);
            check("reset_out_data", 64'(od[k]), 64'(RP));
            check("reset_stall_cnt", 64'(cnt[k]), 64'd0);
            check("reset_in_ready", 64'(ir[k]), 64'd1);
        end
        rst = 1'b0;

        // streaming at full rate: 1-cycle latency, in_ready never drops
        for (int i = 1; i <= 16; i++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k] = 1'b1; id[k] = 39'(i); ordy[k] = 1'b1;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("stream_valid", 64'(ov[k]), 64'd1);
                check("stream_data", 64'(od[k]), 64'(i));
                check("stream_in_ready", 64'(ir[k]), 64'd1);
            end
        end
        idle(0); idle(1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("stream_drain_valid", 64'(ov[k]), 64'd0);
            check("stream_hold_data", 64'(od[k]), 64'h10);
        end

        for (int i = 0; i < 19; i++) begin
            iv[1] = vecs[i].iv; id[1] = vecs[i].d; ordy[1] = vecs[i].ordy;
            fl[1] = vecs[i].fl; clr[1] = vecs[i].clr;
            @(negedge clk);
            check($sformatf("vec%0d_out_valid", i), 64'(ov[1]), 64'(vecs[i].e_ov));
            check($sformatf("vec%0d_out_data", i), 64'(od[1]), 64'(vecs[i].e_od));
            check($sformatf("vec%0d_in_ready", i), 64'(ir[1]), 64'(vecs[i].e_ir));
            check($sformatf("vec%0d_stall_cnt", i), 64'(cnt[1]), 64'(vecs[i].e_cnt));
        end

        // reset while a payload is held and another is being offered
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; id[k] = 39'h66; ordy[k] = 1'b0; fl[k] = 1'b0; clr[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) id[k] = 39'h77;
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("midrst_out_valid", 64'(ov[k]), 64'd0);
            check("midrst_out_data", 64'(od[k]), 64'(RP));
            check("midrst_stall_cnt", 64'(cnt[k]), 64'd0);
        end
        idle(0); idle(1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // randomized traffic against the queue model, both variants together
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                id[k]   = iv[k] ? {$urandom, $urandom} : 'x;
                ordy[k] = ($urandom_range(0, 3) != 0);
                fl[k]   = ($urandom_range(0, 49) == 0);
                clr[k]  = ($urandom_range(0, 99) == 0);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rand%0d_in_ready", k), 64'(ir[k]), 64'(model_ir(k)));
                model_step(k);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rand%0d_out_valid", k), 64'(ov[k]), 64'(m_n[k] > 0));
                check($sformatf("rand%0d_out_data", k), 64'(od[k]), 64'(m_last[k]));
                check($sformatf("rand%0d_stall_cnt", k), 64'(cnt[k]), 64'(m_sc[k]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
